minute_hour_counter: RTL and testbench

- Downstream stage of the seconds counter: consumes its one-cycle roll-over `tick` and keeps minutes and hours of a time-of-day clock.
- Emits its own registered roll-over pulses for later stages (display, alarm compare).
- Has a valid/ready load port so control logic can preset the time without losing a tick that arrives during the load.

---
 rtl/minute_hour_counter.sv | 144 ++++++++++++++
 tb/tb_minute_hour_counter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/minute_hour_counter.sv
// minute_hour_counter
//   Minutes/hours stage of a time-of-day clock. Consumes the one-cycle
//   roll-over pulse of the seconds stage and emits registered roll-over
//   pulses for display and alarm logic. A valid/ready load port presets the
//   time; a tick that lands on a load is held and applied to the loaded value.
//
//   State | Meaning
//   ------+-----------------------------------------------------------
//   IDLE  | single cycle after reset, set_ready still low
//   COUNT | normal counting, loads accepted (set_ready=1)
//   LOAD  | one cycle after an accepted load; deferred tick applied here
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   tick_in           one minute elapsed (single-cycle pulse)
//   run               1 = count ticks, 0 = hold and discard ticks
//   set_valid/ready   load handshake
//   set_minutes/hours load values (range-checked)
//   minutes/hours     current count
//   minute_tick       pulse on minute wrap
//   day_tick          pulse when minutes and hours both wrap
//   set_error         pulse when an accepted load was out of range
module minute_hour_counter #(
  parameter int MIN_MOD  = 60,
  parameter int HOUR_MOD = 24,
  parameter int W_MIN    = 7,
  parameter int W_HOUR   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_in,
  input  logic              run,
  input  logic              set_valid,
  output logic              set_ready,
  input  logic [W_MIN-1:0]  set_minutes,
  input  logic [W_HOUR-1:0] set_hours,
  output logic [W_MIN-1:0]  minutes,
  output logic [W_HOUR-1:0] hours,
  output logic              minute_tick,
  output logic              day_tick,
  output logic              set_error
);

  localparam logic [W_MIN-1:0]  MIN_LIM   = W_MIN'(MIN_MOD);
  localparam logic [W_MIN-1:0]  MIN_LAST  = W_MIN'(MIN_MOD - 1);
  localparam logic [W_HOUR-1:0] HOUR_LIM  = W_HOUR'(HOUR_MOD);
  localparam logic [W_HOUR-1:0] HOUR_LAST = W_HOUR'(HOUR_MOD - 1);

  typedef enum logic [1:0] {IDLE, COUNT, LOAD} state_t;

  state_t              state, state_next;
  logic                pending, pending_next;
  logic [W_MIN-1:0]    minutes_next;
  logic [W_HOUR-1:0]   hours_next;
  logic                minute_tick_next, day_tick_next, set_error_next;
  logic                do_inc;
  logic                in_range;

  assign in_range = (set_minutes < MIN_LIM) && (set_hours < HOUR_LIM);

  always_comb begin
    state_next       = state;
    pending_next     = pending;
    minutes_next     = minutes;
    hours_next       = hours;
    minute_tick_next = 1'b0;
    day_tick_next    = 1'b0;
    set_error_next   = 1'b0;
    do_inc           = 1'b0;

    case (state)
      IDLE: begin
        state_next   = COUNT;
        pending_next = 1'b0;
      end
      COUNT: begin
        if (set_valid && set_ready) begin
          state_next = LOAD;
          if (in_range) begin
            minutes_next = set_minutes;
            hours_next   = set_hours;
          end else begin
            set_error_next = 1'b1;
          end
          // A tick on the accept edge is deferred to the LOAD cycle so it
          // lands on the freshly loaded value.
          pending_next = run && tick_in;
        end else begin
          do_inc       = run && tick_in;
          pending_next = 1'b0;
        end
      end
      LOAD: begin
        state_next = COUNT;
        // A deferred tick and a new tick together still mean one minute.
        do_inc       = run && (pending || tick_in);
        pending_next = 1'b0;
      end
      default: begin
        state_next   = IDLE;
        pending_next = 1'b0;
      end
    endcase

    // Only reached in non-accept cycles, so minutes/hours are the held values.
    if (do_inc) begin
      if (minutes == MIN_LAST) begin
        minutes_next     = '0;
        minute_tick_next = 1'b1;
        if (hours == HOUR_LAST) begin
          hours_next    = '0;
          day_tick_next = 1'b1;
        end else begin
          hours_next = hours + W_HOUR'(1);
        end
      end else begin
        minutes_next = minutes + W_MIN'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pending     <= 1'b0;
      minutes     <= '0;
      hours       <= '0;
      minute_tick <= 1'b0;
      day_tick    <= 1'b0;
      set_error   <= 1'b0;
      set_ready   <= 1'b0;
    end else begin
      state       <= state_next;
      pending     <= pending_next;
      minutes     <= minutes_next;
      hours       <= hours_next;
      minute_tick <= minute_tick_next;
      day_tick    <= day_tick_next;
      set_error   <= set_error_next;
      set_ready   <= (state_next == COUNT);
    end
  end

endmodule

// File: tb/tb_minute_hour_counter.sv
// Testbench for minute_hour_counter: directed scenarios followed by random
// stimulus; expected outputs come from a minute-of-day reference model and
// are checked by a monitor through a scoreboard queue.
module tb_minute_hour_counter;
  localparam int MIN_MOD  = 60;
  localparam int HOUR_MOD = 24;
  localparam int DAY_MIN  = MIN_MOD * HOUR_MOD;

  typedef struct packed {
    logic [6:0] minutes;
    logic [4:0] hours;
    logic       set_ready;
    logic       minute_tick;
    logic       day_tick;
    logic       set_error;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_in = 1'b0;
  logic       run = 1'b0;
  logic       set_valid = 1'b0;
  logic       set_ready;
  logic [6:0] set_minutes = '0;
  logic [4:0] set_hours = '0;
  logic [6:0] minutes;
  logic [4:0] hours;
  logic       minute_tick, day_tick, set_error;

  int   vectors = 0;
  int   miscompares = 0;
  obs_t exp_q[$];

  // Reference model: time kept as minute-of-day
  int m_t = 0;
  bit m_fresh = 1'b0;
  bit m_load = 1'b0;
  bit m_pend = 1'b0;
  bit m_ready = 1'b0;
  int gap = 10;

  minute_hour_counter #(.MIN_MOD(60), .HOUR_MOD(24), .W_MIN(7), .W_HOUR(5)) dut (
    .clk(clk), .reset(reset), .tick_in(tick_in), .run(run),
    .set_valid(set_valid), .set_ready(set_ready),
    .set_minutes(set_minutes), .set_hours(set_hours),
    .minutes(minutes), .hours(hours),
    .minute_tick(minute_tick), .day_tick(day_tick), .set_error(set_error)
  );

  always #5 clk = ~clk;

  function automatic obs_t model_step(bit r, bit tk, bit rn, bit sv, int sm, int sh);
    obs_t o;
    bit inc = 1'b0, err = 1'b0, mt = 1'b0, dt = 1'b0;
    if (r) begin
      m_t = 0; m_fresh = 1'b1; m_load = 1'b0; m_pend = 1'b0; m_ready = 1'b0;
    end else if (m_fresh) begin
      m_fresh = 1'b0; m_ready = 1'b1;
    end else if (m_load) begin
      m_load = 1'b0; m_ready = 1'b1;
      inc = rn && (m_pend || tk);
      m_pend = 1'b0;
    end else if (sv) begin
      m_load = 1'b1; m_ready = 1'b0;
      if (sm < MIN_MOD && sh < HOUR_MOD) m_t = sh * MIN_MOD + sm;
      else err = 1'b1;
      m_pend = rn && tk;
    end else begin
      inc = rn && tk;
    end
    if (inc) begin
      m_t = (m_t + 1) % DAY_MIN;
      mt = (m_t % MIN_MOD) == 0;
      dt = (m_t == 0);
    end
    o.minutes     = 7'(m_t % MIN_MOD);
    o.hours       = 5'(m_t / MIN_MOD);
    o.set_ready   = m_ready;
    o.minute_tick = mt;
    o.day_tick    = dt;
    o.set_error   = err;
    return o;
  endfunction

  task automatic drive(bit r, bit tk, bit rn, bit sv, int sm, int sh);
    @(negedge clk);
    reset = r; tick_in = tk; run = rn; set_valid = sv;
    set_minutes = 7'(sm); set_hours = 5'(sh);
    exp_q.push_back(model_step(r, tk, rn, sv, sm, sh));
  endtask

  task automatic idle(int n, bit rn);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, rn, 1'b0, 0, 0);
  endtask

  task automatic do_load(int sm, int sh, bit tk);
    drive(1'b0, tk, 1'b1, 1'b1, sm, sh);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    idle(1, 1'b1);
  endtask

  task automatic tick_once(bit rn);
    drive(1'b0, 1'b1, rn, 1'b0, 0, 0);
    idle(2, rn);
  endtask

  // Asynchronous reset must clear outputs before any clock edge
  task automatic reset_now();
    @(negedge clk);
    reset = 1'b1; tick_in = 1'b0; set_valid = 1'b0;
    exp_q.push_back(model_step(1'b1, 1'b0, run, 1'b0, 0, 0));
    #1;
    vectors++;
    if (minutes !== 7'd0 || hours !== 5'd0 || set_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got m=%0d h=%0d rdy=%b, expected m=0 h=0 rdy=0",
               minutes, hours, set_ready);
    end
  endtask

  // Monitor: every clock edge the DUT presents a new registered output
  initial begin
    obs_t e, got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = '{minutes, hours, set_ready, minute_tick, day_tick, set_error};
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL cycle_check @%0t: got m=%0d h=%0d rdy=%b mt=%b dt=%b err=%b, expected m=%0d h=%0d rdy=%b mt=%b dt=%b err=%b",
                   $time, got.minutes, got.hours, got.set_ready, got.minute_tick,
                   got.day_tick, got.set_error, e.minutes, e.hours, e.set_ready,
                   e.minute_tick, e.day_tick, e.set_error);
        end
      end
    end
  end

  initial begin
    bit r, tk, rn, sv;
    int sm, sh;

    drive(1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    idle(2, 1'b1);

    // reset mid-count
    do_load(16, 0, 1'b0);
    tick_once(1'b1);
    reset_now();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    idle(2, 1'b1);

    // day wrap
    do_load(59, 23, 1'b0);
    tick_once(1'b1);

    // hour roll
    do_load(59, 5, 1'b0);
    tick_once(1'b1);

    // load with coincident tick
    do_load(10, 3, 1'b1);

    // bad load keeps previous value
    do_load(4, 1, 1'b0);
    do_load(60, 2, 1'b0);
    do_load(5, 24, 1'b0);

    // hold with run=0, then resume
    for (int i = 0; i < 5; i++) tick_once(1'b0);
    tick_once(1'b1);

    // load accepted while run=0, coincident tick discarded
    drive(1'b0, 1'b1, 1'b0, 1'b1, 30, 12);
    idle(2, 1'b0);

    // random phase
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 299) == 0);
      rn = ($urandom_range(0, 7) != 0);
      tk = !m_load && (gap >= 2) && ($urandom_range(0, 2) == 0);
      sv = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 9))
        0:       begin sm = $urandom_range(0, 127); sh = $urandom_range(0, 31); end
        1, 2:    begin sm = 59; sh = $urandom_range(22, 23); end
        default: begin sm = $urandom_range(0, 59); sh = $urandom_range(0, 23); end
      endcase
      gap = tk ? 0 : gap + 1;
      drive(r, tk, rn, sv, sm, sh);
    end

    idle(1, 1'b1);
    repeat (3) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
